// File: rtl/decoder_3to8.sv
// decoder_3to8: 3-to-8 one-hot select/strobe decoder.
//
// Y is a purely combinational decode of A. Y_q is a registered copy of Y,
// and seen is a sticky mask of every Y bit asserted since the last reset.
// Both are for downstream synchronous logic and debug visibility.
//
// Optional feature macro: DECODER_3X8_ENABLE_EN
//   defined     -> an 'en' input exists. en = 0 forces Y to all-zero, so
//                  Y_q loads 8'h00 and seen holds its value.
//   not defined -> no 'en' port, and the decoder is always enabled.
//
// rst is synchronous and active-high. It clears Y_q and seen only; Y
// ignores it.

module decoder_3to8 (
  input  logic       clk,
  input  logic       rst,
`ifdef DECODER_3X8_ENABLE_EN
  input  logic       en,
`endif
  input  logic [2:0] A,
  output logic [7:0] Y,
  output logic [7:0] Y_q,
  output logic [7:0] seen
);

  logic dec_en;

`ifdef DECODER_3X8_ENABLE_EN
  assign dec_en = en;
`else
  assign dec_en = 1'b1;
`endif

  // Decode A to one-hot. An unknown select propagates as X in simulation.
  always_comb begin
    Y = 8'h00;
    if (dec_en) begin
      case (A)
        3'd0:    Y = 8'b0000_0001;
        3'd1:    Y = 8'b0000_0010;
        3'd2:    Y = 8'b0000_0100;
        3'd3:    Y = 8'b0000_1000;
        3'd4:    Y = 8'b0001_0000;
        3'd5:    Y = 8'b0010_0000;
        3'd6:    Y = 8'b0100_0000;
        3'd7:    Y = 8'b1000_0000;
        default: Y = 'x;
      endcase
    end
  end

  // Register the decoded value for synchronous consumers.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y_q <= 8'h00;
    end else begin
      Y_q <= Y;
    end
  end

  // Accumulate every strobe seen since reset. Bits only clear on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen <= 8'h00;
    end else begin
      seen <= seen | Y;
    end
  end

  // Flag an unknown select being captured into the registers outside reset.
  always_ff @(posedge clk) begin
    if (!rst && dec_en) begin
      assert (!$isunknown(A))
        else $error("decoder_3to8: unknown select captured");
    end
  end

endmodule

// File: tb/tb_decoder_3to8.sv
// Testbench for decoder_3to8: directed vectors with a scoreboard queue.
// Stimulus checks the combinational Y immediately and pushes the expected
// registered state; a monitor pops and compares after each rising edge.

module tb_decoder_3to8;

  logic       clk;
  logic       rst;
  logic [2:0] A;
  logic [7:0] Y;
  logic [7:0] Y_q;
  logic [7:0] seen;
`ifdef DECODER_3X8_ENABLE_EN
  logic       en;
`endif

  typedef struct {
    logic [7:0] yq;
    logic [7:0] sn;
  } exp_t;

  exp_t       sb_q[$];
  int         n_vec;
  int         n_err;
  logic [7:0] seen_m;

  decoder_3to8 dut (
    .clk  (clk),
    .rst  (rst),
`ifdef DECODER_3X8_ENABLE_EN
    .en   (en),
`endif
    .A    (A),
    .Y    (Y),
    .Y_q  (Y_q),
    .seen (seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Change A mid-cycle and check Y without capturing anything.
  task automatic peek(input logic [2:0] a, input logic [7:0] y_exp);
    A = a;
    #1;
    chk("Y_comb_glitch", Y, y_exp);
  endtask

  // Drive one vector from a falling edge, check Y, queue the edge result.
  task automatic apply(input logic [2:0] a, input logic r, input logic [7:0] y_exp);
    exp_t e;
    A   = a;
    rst = r;
    #1;
    chk("Y_comb", Y, y_exp);
    seen_m = r ? 8'h00 : (seen_m | y_exp);
    e.yq   = r ? 8'h00 : y_exp;
    e.sn   = seen_m;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: each rising edge presents a new Y_q/seen pair.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("Y_q", Y_q, e.yq);
        chk("seen", seen, e.sn);
      end
    end
  end

  initial begin
    n_vec  = 0;
    n_err  = 0;
    seen_m = 8'h00;
    rst    = 1'b1;
    A      = 3'd0;
`ifdef DECODER_3X8_ENABLE_EN
    en     = 1'b1;
`endif
    @(negedge clk);

    // Reset state
    apply(3'd0, 1'b1, 8'h01);
    apply(3'd0, 1'b1, 8'h01);

    // First capture after reset, then zero-latency decodes
    apply(3'b000, 1'b0, 8'b0000_0001);
    apply(3'b101, 1'b0, 8'b0010_0000);
    apply(3'b010, 1'b0, 8'b0000_0100);

    // Reset with A = 3: Y keeps decoding, registers clear
    apply(3'b011, 1'b1, 8'b0000_1000);

    // Sweep A = 0..7 from a clean seen
    apply(3'd0, 1'b0, 8'b0000_0001);
    apply(3'd1, 1'b0, 8'b0000_0010);
    apply(3'd2, 1'b0, 8'b0000_0100);
    apply(3'd3, 1'b0, 8'b0000_1000);
    apply(3'd4, 1'b0, 8'b0001_0000);
    apply(3'd5, 1'b0, 8'b0010_0000);
    apply(3'd6, 1'b0, 8'b0100_0000);
    apply(3'd7, 1'b0, 8'b1000_0000);
    chk("seen_full_after_sweep", seen, 8'hFF);

    // Reset, then only the value of A at the edge is captured
    apply(3'd0, 1'b1, 8'h01);
    peek(3'd5, 8'b0010_0000);
    apply(3'd2, 1'b0, 8'b0000_0100);
    chk("seen_only_sampled", seen, 8'b0000_0100);

    // Reset one edge while A = 3; Y unaffected
    apply(3'b011, 1'b1, 8'b0000_1000);
    chk("Y_during_reset", Y, 8'b0000_1000);
    apply(3'd6, 1'b0, 8'b0100_0000);

`ifdef DECODER_3X8_ENABLE_EN
    // Enable gating: en = 0 blanks Y and leaves seen alone
    en = 1'b0;
    apply(3'b111, 1'b0, 8'h00);
    chk("seen_held_en0", seen, 8'b0100_0000);
    en = 1'b1;
    apply(3'b111, 1'b0, 8'b1000_0000);
    chk("seen7_after_en1", seen[7] ? 8'h01 : 8'h00, 8'h01);
`endif

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
